dmx_write_arbiter: RTL and testbench
====================================

# dmx_write_arbiter

Round-robin burst arbiter sharing the single write port of the DMX512 transmitter's 512-channel frame buffer among NUM_REQ requesters, such as a UART command parser, a scene fader and a panel controller. Each requester presents addressed channel writes over a valid/ready handshake, grouped into bursts. The block grants one requester at a time and forwards accepted beats as registered write_addr/write_data/write_en pulses. It also filters illegal channel addresses, bounds burst length and recovers from stalled owners.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- MAX_BURST, 16: beats accepted per grant before forced re-arbitration (1..64).
- STALL_TIMEOUT, 64: cycles a granted requester may hold valid low before the grant is revoked.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  beat is the final beat of the burst.
- req_addr  in  10*NUM_REQ  channel address; requester i uses bits [10i+9:10i].
- req_data  in  8*NUM_REQ  channel value; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot beat acceptance; at most one bit high.
- write_addr  out  10  channel address to the frame buffer.
- write_data  out  8  channel value to the frame buffer.
- write_en  out  1  single-cycle write strobe.
- grant_id  out  3  index of the current or last owner.
- busy  out  1  high while in GRANT.
- err_addr  out  1  one-cycle pulse: an accepted beat was dropped for an illegal address.
- err_id  out  3  requester that caused the last err_addr.

## Operation
- States:
  - ARB: no owner.
  - GRANT: one owner.
- ARB behaviour:
  - If any req_valid is high, select the first valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register the selection as grant_id, clear beat_cnt and stall_cnt, and enter GRANT.
  - Nothing is accepted in the ARB cycle.
- GRANT behaviour:
  - req_ready[grant_id] = 1; all other req_ready bits = 0.
  - req_ready is decoded from registered state only, with no combinational path from req_valid.
  - A beat is accepted when req_valid[grant_id] and req_ready[grant_id] are both high.
- Accepted beat with address 1..512:
  - Next cycle, write_en=1 and write_addr/write_data carry that beat.
- Accepted beat with address 0 (start code, read-only) or 513..1023:
  - The beat is consumed with no write.
  - Next cycle, err_addr=1 and err_id=grant_id.
- beat_cnt increments on every accepted beat, legal or not. It is 7 bits wide.
- Burst ends and the block returns to ARB on the cycle after any of:
  - an accepted beat with req_last=1;
  - the accepted beat that makes beat_cnt equal MAX_BURST;
  - stall_cnt reaching STALL_TIMEOUT.
- stall_cnt:
  - Increments each GRANT cycle with req_valid[grant_id]=0.
  - Clears on any accepted beat.
- On burst end, rr_ptr = (grant_id+1) mod NUM_REQ.
  - A preempted or timed-out requester re-arbitrates normally. Its remaining beats are not lost because they were never accepted.
- When no request is pending, write_addr/write_data hold their last values and write_en=0.

## Timing
- Reset values:
  - write_en=0, write_addr=0, write_data=0.
  - grant_id=0, busy=0, req_ready=0.
  - err_addr=0, err_id=0.
  - rr_ptr=0, state ARB.
- Latency: accepted beat to write_en is exactly 1 cycle.
- Throughput: one beat per cycle within a burst, with one dead ARB cycle between bursts.
  - A lone requester streaming MAX_BURST-beat bursts sees MAX_BURST writes per MAX_BURST+1 cycles.
- The final accepted beat of a burst still produces its write (or err_addr) in the first ARB cycle.
- The ARB cycle may concurrently select the next owner.
- A requester dropping req_valid mid-burst without req_last keeps its grant until the timeout.
- Reset mid-burst:
  - Returns to ARB immediately.
  - The pending registered write is discarded: write_en goes to 0 asynchronously.
- Simultaneous last and MAX_BURST on one beat is a single burst end; rr_ptr advances once.

## Test plan
- Single requester 0 sends a 3-beat burst with addresses 1, 2, 512 and data 0x11, 0x22, 0xFF, last on beat 3 -> three consecutive write_en pulses with matching addr/data, each 1 cycle after acceptance; busy falls after the third.
- All 4 requesters hold valid continuously with 1-beat bursts (last=1) -> grants rotate 0,1,2,3,0; every second cycle carries a write.
- Requester 1 streams 40 beats without last, MAX_BURST=16 while requester 2 is valid -> 16 beats from requester 1, then requester 2's burst, then requester 1 resumes at beat 17; no beat is duplicated or lost.
- Requester 3 sends addresses 0, 513, 5 -> err_addr pulses twice with err_id=3; exactly one write_en, at addr 5.
- Requester 0 is granted, sends 1 beat, then holds valid low -> after 64 idle cycles busy=0, rr_ptr=1, and pending requester 1 is granted on the next ARB cycle.
- rst asserted in the cycle after an accepted beat -> write_en=0 immediately; all outputs at reset values; the state is ARB after release.

Source files
------------

// File: rtl/dmx_write_arbiter_if.sv
// Requester-side handshake and frame-buffer write bus of the DMX512 write arbiter.
// The arbiter connects via the slave modport.
interface dmx_write_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [10*NUM_REQ-1:0] req_addr;
  logic [8*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [9:0]            write_addr;
  logic [7:0]            write_data;
  logic                  write_en;
  logic [2:0]            grant_id;
  logic                  busy;
  logic                  err_addr;
  logic [2:0]            err_id;

  modport master (
    output req_valid, req_last, req_addr, req_data,
    input  req_ready, write_addr, write_data, write_en, grant_id, busy, err_addr, err_id
  );

  modport slave (
    input  req_valid, req_last, req_addr, req_data,
    output req_ready, write_addr, write_data, write_en, grant_id, busy, err_addr, err_id
  );
endinterface

// File: rtl/dmx_write_arbiter.sv
// Round-robin burst arbiter for the single write port of the DMX512 frame buffer.
// Filters illegal channel addresses, caps burst length and revokes stalled grants.
module dmx_write_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  dmx_write_arbiter_if.slave bus
);
  localparam int SW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [0:0] {ARB = 1'b0, GRANT = 1'b1} state_e;

  // Channel 0 is the start code slot and is never writable.
  function automatic logic addr_legal(input logic [9:0] a);
    return (a != 10'd0) && (a <= 10'd512);
  endfunction

  state_e             state_q, state_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic [2:0]         rr_ptr_q, rr_ptr_d;
  logic [6:0]         beat_cnt_q, beat_cnt_d;
  logic [SW-1:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               write_en_q, write_en_d;
  logic [9:0]         write_addr_q, write_addr_d;
  logic [7:0]         write_data_q, write_data_d;
  logic               err_addr_q, err_addr_d;
  logic [2:0]         err_id_q, err_id_d;

  logic               cur_valid_s, cur_last_s, accept_s, end_burst_s;
  logic [9:0]         cur_addr_s;
  logic [7:0]         cur_data_s;
  logic [NUM_REQ-1:0] rot_s;
  logic [2:0]         sel_off_s, sel_id_s;
  int                 sel_sum_s;

  // Mux the owner's beat; accept only against the registered one-hot ready.
  always_comb begin
    cur_valid_s = 1'b0;
    cur_last_s  = 1'b0;
    cur_addr_s  = 10'd0;
    cur_data_s  = 8'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cur_valid_s |= bus.req_valid[i] & (grant_id_q == 3'(i));
      cur_last_s  |= bus.req_last[i]  & (grant_id_q == 3'(i));
      cur_addr_s  |= bus.req_addr[10*i +: 10] & {10{grant_id_q == 3'(i)}};
      cur_data_s  |= bus.req_data[8*i +: 8]   & {8{grant_id_q == 3'(i)}};
    end
    accept_s = |(bus.req_valid & req_ready_q);
  end

  // Round-robin pick: rotate so rr_ptr sits at bit 0, take the lowest set bit.
  always_comb begin
    rot_s     = NUM_REQ'({bus.req_valid, bus.req_valid} >> rr_ptr_q);
    sel_off_s = 3'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel_off_s = rot_s[k] ? 3'(k) : sel_off_s;
    end
    sel_sum_s = int'(rr_ptr_q) + int'(sel_off_s);
    sel_id_s  = (sel_sum_s >= NUM_REQ) ? 3'(sel_sum_s - NUM_REQ) : 3'(sel_sum_s);
  end

  // Next-state and next-output logic for the ARB/GRANT controller.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    err_addr_d   = 1'b0;
    err_id_d     = err_id_q;
    end_burst_s  = 1'b0;
    case (state_q)
      ARB: begin
        if (|bus.req_valid) begin
          state_d     = GRANT;
          grant_id_d  = sel_id_s;
          beat_cnt_d  = 7'd0;
          stall_cnt_d = {SW{1'b0}};
        end else begin
          state_d = ARB;
        end
      end
      GRANT: begin
        if (accept_s) begin
          beat_cnt_d  = beat_cnt_q + 7'd1;
          stall_cnt_d = {SW{1'b0}};
          if (addr_legal(cur_addr_s)) begin
            write_en_d   = 1'b1;
            write_addr_d = cur_addr_s;
            write_data_d = cur_data_s;
          end else begin
            err_addr_d = 1'b1;
            err_id_d   = grant_id_q;
          end
          end_burst_s = cur_last_s || (beat_cnt_d == 7'(MAX_BURST));
        end else if (!cur_valid_s) begin
          stall_cnt_d = stall_cnt_q + SW'(1);
          end_burst_s = (stall_cnt_d == SW'(STALL_TIMEOUT));
        end else begin
          end_burst_s = 1'b0;
        end
        // Last beat and MAX_BURST on the same beat still advance rr_ptr once.
        if (end_burst_s) begin
          state_d  = ARB;
          rr_ptr_d = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
        end else begin
          state_d = GRANT;
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
    busy_d = (state_d == GRANT);
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_d[i] = busy_d & (grant_id_d == 3'(i));
    end
  end

  // State and registered outputs; reset also discards a pending write strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      grant_id_q   <= 3'd0;
      rr_ptr_q     <= 3'd0;
      beat_cnt_q   <= 7'd0;
      stall_cnt_q  <= {SW{1'b0}};
      req_ready_q  <= {NUM_REQ{1'b0}};
      busy_q       <= 1'b0;
      write_en_q   <= 1'b0;
      write_addr_q <= 10'd0;
      write_data_q <= 8'd0;
      err_addr_q   <= 1'b0;
      err_id_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      rr_ptr_q     <= rr_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      err_addr_q   <= err_addr_d;
      err_id_q     <= err_id_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.write_en   = write_en_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;
  assign bus.err_addr   = err_addr_q;
  assign bus.err_id     = err_id_q;
endmodule

// File: tb/tb_dmx_write_arbiter.sv
// Directed self-checking bench for dmx_write_arbiter (NUM_REQ=4, MAX_BURST=16, STALL_TIMEOUT=64).
module tb_dmx_write_arbiter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  dmx_write_arbiter_if #(.NUM_REQ(4)) bus ();

  dmx_write_arbiter #(.NUM_REQ(4), .MAX_BURST(16), .STALL_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [9:0] a, input logic [7:0] d);
    bus.req_valid[i]        = v;
    bus.req_last[i]         = l;
    bus.req_addr[10*i +: 10] = a;
    bus.req_data[8*i +: 8]   = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid = 4'd0;
    bus.req_last  = 4'd0;
    bus.req_addr  = 40'd0;
    bus.req_data  = 32'd0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.write_en, bus.write_addr, bus.write_data, bus.grant_id, bus.busy, bus.req_ready, bus.err_addr, bus.err_id} !== 30'd0) begin
      n_bad++; $display("FAIL reset_outputs got en=%0b addr=%0d data=%0h gid=%0d busy=%0b rdy=%0b err=%0b eid=%0d exp all zero",
        bus.write_en, bus.write_addr, bus.write_data, bus.grant_id, bus.busy, bus.req_ready, bus.err_addr, bus.err_id);
    end
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({bus.busy, bus.req_ready, bus.write_en} !== 6'd0) begin
      n_bad++; $display("FAIL reset_idle got busy=%0b rdy=%0b en=%0b exp 0/0/0", bus.busy, bus.req_ready, bus.write_en);
    end
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 1'b0, 10'd1, 8'h11);
    step();
    n_cmp++;
    if ({bus.busy, bus.grant_id, bus.req_ready, bus.write_en} !== {1'b1, 3'd0, 4'b0001, 1'b0}) begin
      n_bad++; $display("FAIL single_grant got busy=%0b gid=%0d rdy=%b en=%0b exp 1/0/0001/0", bus.busy, bus.grant_id, bus.req_ready, bus.write_en);
    end
    step();
    n_cmp++;
    if ({bus.write_en, bus.write_addr, bus.write_data} !== {1'b1, 10'd1, 8'h11}) begin
      n_bad++; $display("FAIL single_beat1 got en=%0b addr=%0d data=%0h exp 1/1/11", bus.write_en, bus.write_addr, bus.write_data);
    end
    set_req(0, 1'b1, 1'b0, 10'd2, 8'h22);
    step();
    n_cmp++;
    if ({bus.write_en, bus.write_addr, bus.write_data, bus.busy} !== {1'b1, 10'd2, 8'h22, 1'b1}) begin
      n_bad++; $display("FAIL single_beat2 got en=%0b addr=%0d data=%0h busy=%0b exp 1/2/22/1", bus.write_en, bus.write_addr, bus.write_data, bus.busy);
    end
    set_req(0, 1'b1, 1'b1, 10'd512, 8'hFF);
    step();
    n_cmp++;
    if ({bus.write_en, bus.write_addr, bus.write_data, bus.busy, bus.req_ready} !== {1'b1, 10'd512, 8'hFF, 1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL single_beat3 got en=%0b addr=%0d data=%0h busy=%0b rdy=%b exp 1/512/ff/0/0000",
        bus.write_en, bus.write_addr, bus.write_data, bus.busy, bus.req_ready);
    end
    clear_reqs();
    step();
    n_cmp++;
    if ({bus.write_en, bus.write_addr, bus.write_data, bus.busy} !== {1'b0, 10'd512, 8'hFF, 1'b0}) begin
      n_bad++; $display("FAIL single_hold got en=%0b addr=%0d data=%0h busy=%0b exp 0/512/ff/0", bus.write_en, bus.write_addr, bus.write_data, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] order [5];
    order[0] = 3'd0; order[1] = 3'd1; order[2] = 3'd2; order[3] = 3'd3; order[4] = 3'd0;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 10'(10 + i), 8'(i));
    for (int n = 0; n < 5; n++) begin
      step();
      n_cmp++;
      if ({bus.busy, bus.grant_id, bus.write_en} !== {1'b1, order[n], 1'b0}) begin
        n_bad++; $display("FAIL rr_grant%0d got busy=%0b gid=%0d en=%0b exp 1/%0d/0", n, bus.busy, bus.grant_id, bus.write_en, order[n]);
      end
      step();
      n_cmp++;
      if ({bus.busy, bus.write_en, bus.write_addr, bus.write_data} !== {1'b0, 1'b1, 10'd10 + 10'(order[n]), 8'(order[n])}) begin
        n_bad++; $display("FAIL rr_write%0d got busy=%0b en=%0b addr=%0d data=%0h exp 0/1/%0d/%0h",
          n, bus.busy, bus.write_en, bus.write_addr, bus.write_data, 10 + order[n], order[n]);
      end
    end
    clear_reqs();
    step();
  endtask

  task automatic test_max_burst_preempt();
    logic [17:0] got [$];
    logic [17:0] exp_w [$];
    logic [3:0]  rdy;
    logic [3:0]  vld;
    int          r1;
    int          r2;
    bit          done;
    r1 = 0; r2 = 0; done = 1'b0;
    for (int k = 0; k < 16; k++) exp_w.push_back({10'(100 + k), 8'(k)});
    exp_w.push_back({10'd300, 8'h80});
    exp_w.push_back({10'd301, 8'h81});
    for (int k = 16; k < 40; k++) exp_w.push_back({10'(100 + k), 8'(k)});
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      set_req(1, r1 < 40, 1'b0, 10'(100 + r1), 8'(r1));
      set_req(2, r2 < 2, r2 == 1, 10'(300 + r2), 8'(8'h80 + r2));
      rdy = bus.req_ready;
      vld = bus.req_valid;
      step();
      if (rdy[1] && vld[1]) r1++;
      if (rdy[2] && vld[2]) r2++;
      if (bus.write_en) got.push_back({bus.write_addr, bus.write_data});
      if (r1 == 40 && r2 == 2 && !bus.busy) done = 1'b1;
    end
    clear_reqs();
    n_cmp++;
    if (!done) begin
      n_bad++; $display("FAIL burst_timeout got r1=%0d r2=%0d busy=%0b exp r1=40 r2=2 busy=0", r1, r2, bus.busy);
    end
    n_cmp++;
    if (got.size() !== 42) begin
      n_bad++; $display("FAIL burst_count got %0d writes exp 42", got.size());
    end
    for (int k = 0; k < 42 && k < got.size(); k++) begin
      n_cmp++;
      if (got[k] !== exp_w[k]) begin
        n_bad++; $display("FAIL burst_order[%0d] got addr=%0d data=%0h exp addr=%0d data=%0h",
          k, got[k][17:8], got[k][7:0], exp_w[k][17:8], exp_w[k][7:0]);
      end
    end
  endtask

  task automatic test_err_addr();
    set_req(3, 1'b1, 1'b0, 10'd0, 8'hA0);
    step();
    n_cmp++;
    if ({bus.busy, bus.grant_id} !== {1'b1, 3'd3}) begin
      n_bad++; $display("FAIL err_grant got busy=%0b gid=%0d exp 1/3", bus.busy, bus.grant_id);
    end
    step();
    n_cmp++;
    if ({bus.err_addr, bus.err_id, bus.write_en, bus.write_addr} !== {1'b1, 3'd3, 1'b0, 10'd139}) begin
      n_bad++; $display("FAIL err_addr0 got err=%0b eid=%0d en=%0b waddr=%0d exp 1/3/0/139", bus.err_addr, bus.err_id, bus.write_en, bus.write_addr);
    end
    set_req(3, 1'b1, 1'b0, 10'd513, 8'hA1);
    step();
    n_cmp++;
    if ({bus.err_addr, bus.err_id, bus.write_en} !== {1'b1, 3'd3, 1'b0}) begin
      n_bad++; $display("FAIL err_addr513 got err=%0b eid=%0d en=%0b exp 1/3/0", bus.err_addr, bus.err_id, bus.write_en);
    end
    set_req(3, 1'b1, 1'b1, 10'd5, 8'hA5);
    step();
    n_cmp++;
    if ({bus.err_addr, bus.err_id, bus.write_en, bus.write_addr, bus.write_data, bus.busy} !== {1'b0, 3'd3, 1'b1, 10'd5, 8'hA5, 1'b0}) begin
      n_bad++; $display("FAIL err_legal got err=%0b eid=%0d en=%0b addr=%0d data=%0h busy=%0b exp 0/3/1/5/a5/0",
        bus.err_addr, bus.err_id, bus.write_en, bus.write_addr, bus.write_data, bus.busy);
    end
    clear_reqs();
    step();
  endtask

  task automatic test_stall_timeout();
    do_reset();
    set_req(0, 1'b1, 1'b0, 10'd7, 8'h07);
    set_req(1, 1'b1, 1'b1, 10'd30, 8'h33);
    step();
    n_cmp++;
    if ({bus.busy, bus.grant_id} !== {1'b1, 3'd0}) begin
      n_bad++; $display("FAIL stall_grant got busy=%0b gid=%0d exp 1/0", bus.busy, bus.grant_id);
    end
    step();
    n_cmp++;
    if ({bus.write_en, bus.write_addr} !== {1'b1, 10'd7}) begin
      n_bad++; $display("FAIL stall_beat got en=%0b addr=%0d exp 1/7", bus.write_en, bus.write_addr);
    end
    set_req(0, 1'b0, 1'b0, 10'd7, 8'h07);
    repeat (63) step();
    n_cmp++;
    if ({bus.busy, bus.grant_id} !== {1'b1, 3'd0}) begin
      n_bad++; $display("FAIL stall_held got busy=%0b gid=%0d exp 1/0", bus.busy, bus.grant_id);
    end
    step();
    n_cmp++;
    if ({bus.busy, bus.req_ready} !== {1'b0, 4'b0000}) begin
      n_bad++; $display("FAIL stall_revoke got busy=%0b rdy=%b exp 0/0000", bus.busy, bus.req_ready);
    end
    set_req(0, 1'b1, 1'b0, 10'd7, 8'h07);
    step();
    n_cmp++;
    if ({bus.busy, bus.grant_id, bus.req_ready} !== {1'b1, 3'd1, 4'b0010}) begin
      n_bad++; $display("FAIL stall_next got busy=%0b gid=%0d rdy=%b exp 1/1/0010", bus.busy, bus.grant_id, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 1'b1, 1'b0, 10'd20, 8'h5A);
    step();
    step();
    n_cmp++;
    if ({bus.write_en, bus.write_addr} !== {1'b1, 10'd20}) begin
      n_bad++; $display("FAIL rstmid_beat got en=%0b addr=%0d exp 1/20", bus.write_en, bus.write_addr);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.write_en, bus.write_addr, bus.write_data, bus.grant_id, bus.busy, bus.req_ready, bus.err_addr, bus.err_id} !== 30'd0) begin
      n_bad++; $display("FAIL rstmid_async got en=%0b addr=%0d data=%0h gid=%0d busy=%0b rdy=%b exp all zero",
        bus.write_en, bus.write_addr, bus.write_data, bus.grant_id, bus.busy, bus.req_ready);
    end
    step();
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.busy, bus.req_ready, bus.write_en} !== 6'd0) begin
      n_bad++; $display("FAIL rstmid_arb got busy=%0b rdy=%b en=%0b exp 0/0000/0", bus.busy, bus.req_ready, bus.write_en);
    end
    step();
    n_cmp++;
    if ({bus.busy, bus.grant_id, bus.req_ready, bus.write_en} !== {1'b1, 3'd0, 4'b0001, 1'b0}) begin
      n_bad++; $display("FAIL rstmid_regrant got busy=%0b gid=%0d rdy=%b en=%0b exp 1/0/0001/0", bus.busy, bus.grant_id, bus.req_ready, bus.write_en);
    end
    clear_reqs();
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_max_burst_preempt();
    test_err_addr();
    test_stall_timeout();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
